// File: rtl/instr_encoder_loader.sv
// Instruction encoder and program loader: packs R/I/U fields into RV32 words
// and writes them to consecutive instruction-memory addresses, one per handshake.
module instr_encoder_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int START_WORD = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start_i,
   input  logic [ADDR_WIDTH-1:0] Count_i,
   input  logic                  Valid_i,
   output logic                  Ready_o,
   input  logic [1:0]            Fmt_i,
   input  logic [4:0]            Rd_i,
   input  logic [4:0]            Rs1_i,
   input  logic [4:0]            Rs2_i,
   input  logic [2:0]            Funct3_i,
   input  logic [6:0]            Funct7_i,
   input  logic [19:0]           Imm_i,
   output logic                  Mem_Write_o,
   output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
   output logic [31:0]           Mem_Data_o,
   output logic                  Busy_o,
   output logic                  Done_o,
   output logic                  Error_o,
   output logic [ADDR_WIDTH-1:0] Words_o,
   output logic [1:0]            State_o
);

   // Handshake: a field transfer happens on a rising edge where Valid_i and
   // Ready_o are both high; Ready_o is high only in ACCEPT and never depends on Valid_i.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(START_WORD);
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] words_q, words_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_data_q, mem_data_d;
   logic [31:0]           enc_data;

   always_comb begin
      enc_data = '0;
      case (Fmt_i)
         2'b00:   enc_data = {Funct7_i, Rs2_i, Rs1_i, Funct3_i, Rd_i, OP_R};
         2'b01:   enc_data = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, OP_I};
         2'b10:   enc_data = {Imm_i, Rd_i, OP_LUI};
         default: enc_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         addr_q     <= '0;
         words_q    <= '0;
         error_q    <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         words_q    <= words_d;
         error_q    <= error_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      words_d     = words_q;
      error_d     = error_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      Ready_o     = 1'b0;
      Mem_Write_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start_i) begin
               count_d = Count_i;
               addr_d  = START_ADDR;
               words_d = '0;
               error_d = 1'b0;
               state_d = (Count_i == '0) ? DONE : ACCEPT;
            end
         end
         ACCEPT: begin
            Ready_o = 1'b1;
            if (Valid_i) begin
               if (Fmt_i == 2'b11) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  // Separate output registers keep address/data stable after the strobe.
                  mem_addr_d = addr_q;
                  mem_data_d = enc_data;
                  state_d    = WRITE;
               end
            end
         end
         WRITE: begin
            Mem_Write_o = 1'b1;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            words_d     = words_q + ADDR_WIDTH'(1);
            state_d     = (words_q + ADDR_WIDTH'(1) == count_q) ? DONE : ACCEPT;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Mem_Addr_o = mem_addr_q;
   assign Mem_Data_o = mem_data_q;
   assign Busy_o     = (state_q != IDLE);
   assign Done_o     = (state_q == DONE);
   assign Error_o    = error_q;
   assign Words_o    = words_q;
   assign State_o    = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (start word 0 and 62) share one
// stimulus stream; monitors check writes and session ends against a queue model.
module tb_instr_encoder_loader;

   localparam int AW = 6;
   localparam int START0 = 0;
   localparam int START1 = 62;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          Start_i = 1'b0;
   logic [AW-1:0] Count_i = '0;
   logic          Valid_i = 1'b0;
   logic [1:0]    Fmt_i = '0;
   logic [4:0]    Rd_i = '0, Rs1_i = '0, Rs2_i = '0;
   logic [2:0]    Funct3_i = '0;
   logic [6:0]    Funct7_i = '0;
   logic [19:0]   Imm_i = '0;

   logic          rdy0, wr0, busy0, done0, err0;
   logic [AW-1:0] addr0, words0;
   logic [31:0]   data0;
   logic [1:0]    st0;
   logic          rdy1, wr1, busy1, done1, err1;
   logic [AW-1:0] addr1, words1;
   logic [31:0]   data1;
   logic [1:0]    st1;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_WIDTH(AW), .START_WORD(START0)) dut0 (
      .clk(clk), .reset(reset), .Start_i(Start_i), .Count_i(Count_i),
      .Valid_i(Valid_i), .Ready_o(rdy0), .Fmt_i(Fmt_i), .Rd_i(Rd_i),
      .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Funct3_i(Funct3_i), .Funct7_i(Funct7_i),
      .Imm_i(Imm_i), .Mem_Write_o(wr0), .Mem_Addr_o(addr0), .Mem_Data_o(data0),
      .Busy_o(busy0), .Done_o(done0), .Error_o(err0), .Words_o(words0), .State_o(st0)
   );

   instr_encoder_loader #(.ADDR_WIDTH(AW), .START_WORD(START1)) dut1 (
      .clk(clk), .reset(reset), .Start_i(Start_i), .Count_i(Count_i),
      .Valid_i(Valid_i), .Ready_o(rdy1), .Fmt_i(Fmt_i), .Rd_i(Rd_i),
      .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Funct3_i(Funct3_i), .Funct7_i(Funct7_i),
      .Imm_i(Imm_i), .Mem_Write_o(wr1), .Mem_Addr_o(addr1), .Mem_Data_o(data1),
      .Busy_o(busy1), .Done_o(done1), .Error_o(err1), .Words_o(words1), .State_o(st1)
   );

   int tests = 0;
   int fails = 0;
   logic [AW+31:0] exp0_q[$];
   logic [AW+31:0] exp1_q[$];
   logic [AW:0]    dexp0_q[$];
   logic [AW:0]    dexp1_q[$];
   int sess_count = 0;
   int sess_words = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      tests++;
      fails++;
      $display("FAIL %s actual=%s required=none", name, what);
   endtask

   // Reference encoding built from field weights rather than bit concatenation.
   function automatic logic [31:0] model_enc(input int fmt, input int rd, input int rs1,
                                             input int rs2, input int f3, input int f7,
                                             input int imm);
      longint v;
      case (fmt)
         0: v = 64'h33 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                + longint'(f7) * 33554432;
         1: v = 64'h13 + rd * 128 + f3 * 4096 + rs1 * 32768 + longint'(imm % 4096) * 1048576;
         2: v = 64'h37 + rd * 128 + longint'(imm) * 4096;
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   always @(negedge clk) begin
      if (wr0) begin
         if (exp0_q.size() == 0) fail_now("wr0_unexpected", $sformatf("%0h:%08h", addr0, data0));
         else check("wr0", {addr0, data0}, exp0_q.pop_front());
      end
      if (wr1) begin
         if (exp1_q.size() == 0) fail_now("wr1_unexpected", $sformatf("%0h:%08h", addr1, data1));
         else check("wr1", {addr1, data1}, exp1_q.pop_front());
      end
      if (done0) begin
         if (dexp0_q.size() == 0) fail_now("done0_unexpected", $sformatf("%0h", words0));
         else check("done0_words_err", {words0, err0}, dexp0_q.pop_front());
      end
      if (done1) begin
         if (dexp1_q.size() == 0) fail_now("done1_unexpected", $sformatf("%0h", words1));
         else check("done1_words_err", {words1, err1}, dexp1_q.pop_front());
      end
   end

   task automatic push_done(input int words, input bit err);
      dexp0_q.push_back({AW'(words), err});
      dexp1_q.push_back({AW'(words), err});
   endtask

   task automatic start_session(input int count);
      int n = 0;
      while ((busy0 || busy1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_now("idle_timeout", "busy");
      @(negedge clk);
      Start_i = 1'b1;
      Count_i = AW'(count);
      sess_count = count;
      sess_words = 0;
      if (count == 0) push_done(0, 1'b0);
      @(posedge clk);
      #1;
      Start_i = 1'b0;
      check("err_clear", {err0, err1}, 2'b00);
      check("words_clear", {words0, words1}, '0);
      if (count == 0) check("zero_done", {done0, done1, busy0}, 3'b111);
      else check("start_ready", {rdy0, rdy1}, 2'b11);
   endtask

   task automatic send_word(input int fmt, input int rd, input int rs1, input int rs2,
                            input int f3, input int f7, input int imm, input int stall);
      int n = 0;
      repeat (stall) @(negedge clk);
      @(negedge clk);
      Fmt_i = 2'(fmt);
      Rd_i = 5'(rd);
      Rs1_i = 5'(rs1);
      Rs2_i = 5'(rs2);
      Funct3_i = 3'(f3);
      Funct7_i = 7'(f7);
      Imm_i = 20'(imm);
      Valid_i = 1'b1;
      while (!rdy0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         fail_now("ready_timeout", "low");
         Valid_i = 1'b0;
         return;
      end
      if (fmt == 3) begin
         push_done(sess_words, 1'b1);
      end else begin
         exp0_q.push_back({AW'((START0 + sess_words) % 64), model_enc(fmt, rd, rs1, rs2, f3, f7, imm)});
         exp1_q.push_back({AW'((START1 + sess_words) % 64), model_enc(fmt, rd, rs1, rs2, f3, f7, imm)});
         sess_words++;
         if (sess_words == sess_count) push_done(sess_words, 1'b0);
      end
      @(posedge clk);
      #1;
      Valid_i = 1'b0;
   endtask

   task automatic send_random(input int fmt, input int stall);
      send_word(fmt, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 1048575), stall);
   endtask

   task automatic check_outs_zero(input string name);
      check({name, "_0"}, {rdy0, wr0, busy0, done0, err0, addr0, data0, words0}, '0);
      check({name, "_1"}, {rdy1, wr1, busy1, done1, err1, addr1, data1, words1}, '0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_outs_zero("reset_hold");
      reset = 1'b1;

      // Reset asserted mid-cycle while Start_i is high.
      @(negedge clk);
      Start_i = 1'b1;
      Count_i = AW'(3);
      @(posedge clk);
      #1;
      check("start_latency", {rdy0, busy0}, 2'b11);
      #2;
      reset = 1'b0;
      #1;
      check_outs_zero("async_reset");
      Start_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {st0, st1, busy0}, '0);

      // Mixed formats.
      start_session(3);
      send_word(0, 3, 1, 2, 0, 0, 0, 0);
      send_word(1, 5, 0, 0, 0, 0, 'h7FF, 0);
      send_word(2, 10, 0, 0, 0, 0, 'h12345, 0);

      // Stall gap and an all-ones I immediate.
      start_session(2);
      send_word(1, 1, 1, 0, 6, 0, 'hFFF, 0);
      send_random(0, 5);

      // Illegal format on the second word, then a session that clears the flag.
      start_session(4);
      send_random(2, 0);
      send_random(3, 0);
      start_session(4);
      for (int k = 0; k < 4; k++) send_random($urandom_range(0, 2), 0);

      start_session(0);

      // Start_i while waiting in ACCEPT must be ignored.
      start_session(2);
      send_random(1, 0);
      repeat (2) @(negedge clk);
      Start_i = 1'b1;
      Count_i = AW'(5);
      @(posedge clk);
      #1;
      Start_i = 1'b0;
      check("start_ignored", {st0, busy0, words0}, {2'd1, 1'b1, AW'(1)});
      send_random(0, 1);

      // Reset during the write strobe.
      start_session(2);
      @(negedge clk);
      Fmt_i = 2'b00;
      Valid_i = 1'b1;
      @(posedge clk);
      #1;
      Valid_i = 1'b0;
      check("write_strobe", {wr0, wr1}, 2'b11);
      #2;
      reset = 1'b0;
      #1;
      check("reset_in_write", {wr0, wr1, busy0, busy1}, '0);
      @(negedge clk);
      reset = 1'b1;

      // Random sessions with occasional illegal words and random stalls.
      for (int s = 0; s < 12; s++) begin
         int cnt;
         int ill;
         cnt = $urandom_range(0, 7);
         ill = -1;
         if (cnt > 0 && $urandom_range(0, 3) == 0) ill = $urandom_range(0, cnt - 1);
         start_session(cnt);
         for (int k = 0; k < cnt; k++) begin
            if (k == ill) begin
               send_random(3, $urandom_range(0, 3));
               break;
            end
            send_random($urandom_range(0, 2), $urandom_range(0, 3));
         end
      end

      repeat (10) @(negedge clk);
      check("queues_drained", exp0_q.size() + exp1_q.size() + dexp0_q.size() + dexp1_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
